// File: rtl/order_ingress_arbiter.sv
// Round-robin order ingress arbiter with per-source token-bucket limiting,
// a registered output stage and per-source accepted-order counters.
module order_ingress_arbiter #(
  parameter int NUM_SRC       = 3,
  parameter int DATA_W        = 32,
  parameter int TOKEN_MAX     = 8,
  parameter int REFILL_PERIOD = 16,
  localparam int SEL_W        = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arb_enable,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [DATA_W-1:0]         order_data,
  output logic                      order_valid,
  input  logic                      order_ready,
  output logic [SEL_W-1:0]          order_src,
  input  logic [SEL_W-1:0]          stat_sel,
  input  logic                      stat_clear,
  output logic [31:0]               stat_count
);

  localparam logic [7:0]       TOK_MAX = 8'(TOKEN_MAX);
  localparam logic [15:0]      TMR_END = 16'(REFILL_PERIOD - 1);
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_SRC - 1);

  logic [7:0]        tok_q [NUM_SRC];
  logic [7:0]        tok_d [NUM_SRC];
  logic [31:0]       stat_q [NUM_SRC];
  logic [31:0]       stat_d [NUM_SRC];
  logic [15:0]       tmr_q;
  logic [SEL_W-1:0]  last_q;
  logic [DATA_W-1:0] data_q;
  logic [SEL_W-1:0]  src_q;
  logic              ov_q;

  logic [NUM_SRC-1:0] elig;
  logic               pipe_ready;
  logic               found;
  logic [SEL_W-1:0]   gnt;
  logic               xfer;
  logic               wrap;
  int                 idx;

  assign pipe_ready = !ov_q || order_ready;
  assign wrap       = (tmr_q == TMR_END);

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i] = src_valid[i] && (tok_q[i] != 8'd0);
    end
  end

  // Scan starts just after the last winner and wraps around.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(last_q) + k) % NUM_SRC;
      if (!found && elig[idx]) begin
        found = 1'b1;
        gnt   = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    src_ready = '0;
    if (rst_n && arb_enable && pipe_ready && found) begin
      src_ready[gnt] = 1'b1;
    end
  end

  assign xfer = |(src_valid & src_ready);

  // Simultaneous refill and consume cancel out.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      tok_d[i] = tok_q[i];
      if (xfer && (gnt == SEL_W'(i))) begin
        if (!(wrap && tok_q[i] < TOK_MAX)) begin
          tok_d[i] = tok_q[i] - 8'd1;
        end
      end else if (wrap && tok_q[i] < TOK_MAX) begin
        tok_d[i] = tok_q[i] + 8'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      stat_d[i] = stat_q[i];
      if (stat_clear) begin
        stat_d[i] = '0;
      end else if (xfer && (gnt == SEL_W'(i))) begin
        stat_d[i] = stat_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q  <= '0;
      last_q <= LAST_RST;
      data_q <= '0;
      src_q  <= '0;
      ov_q   <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        tok_q[i]  <= TOK_MAX;
        stat_q[i] <= '0;
      end
    end else begin
      tmr_q <= wrap ? 16'd0 : tmr_q + 16'd1;
      for (int i = 0; i < NUM_SRC; i++) begin
        tok_q[i]  <= tok_d[i];
        stat_q[i] <= stat_d[i];
      end
      if (xfer) begin
        data_q <= src_data[gnt*DATA_W +: DATA_W];
        src_q  <= gnt;
        ov_q   <= 1'b1;
        last_q <= gnt;
      end else if (order_ready) begin
        ov_q <= 1'b0;
      end
    end
  end

  always_comb begin
    stat_count = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (stat_sel == SEL_W'(i)) begin
        stat_count = stat_q[i];
      end
    end
  end

  assign order_data  = data_q;
  assign order_valid = ov_q;
  assign order_src   = src_q;

endmodule

// File: tb/tb_order_ingress_arbiter.sv
// Directed bench for order_ingress_arbiter: vector table plus
// hand-written rate-limit, starvation, clear and reset sequences.
module tb_order_ingress_arbiter;

  localparam logic [31:0] DA = 32'hA0000001;
  localparam logic [31:0] DB = 32'hB0000002;
  localparam logic [31:0] DC = 32'hC0000003;
  localparam logic [31:0] DX = 32'h80000005;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arb_enable = 1'b0;
  logic [95:0] src_data;
  logic [2:0]  src_valid = '0;
  logic [2:0]  src_ready;
  logic [31:0] order_data;
  logic        order_valid;
  logic        order_ready = 1'b1;
  logic [1:0]  order_src;
  logic [1:0]  stat_sel = '0;
  logic        stat_clear = 1'b0;
  logic [31:0] stat_count;
  logic [31:0] d1 = DB;

  int checks = 0;
  int failures = 0;

  logic [2:0]  rdy_s;
  logic [31:0] stat_s;

  assign src_data = {DC, d1, DA};

  always #5 clk = ~clk;

  order_ingress_arbiter dut (
    .clk(clk),
    .rst_n(rst_n),
    .arb_enable(arb_enable),
    .src_data(src_data),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .order_data(order_data),
    .order_valid(order_valid),
    .order_ready(order_ready),
    .order_src(order_src),
    .stat_sel(stat_sel),
    .stat_clear(stat_clear),
    .stat_count(stat_count)
  );

  typedef struct {
    logic [2:0]  v;
    logic        ordy;
    logic        en;
    logic [1:0]  sel;
    logic [31:0] d1;
    logic [2:0]  e_rdy;
    logic        e_ov;
    logic [1:0]  e_os;
    logic [31:0] e_od;
    logic [31:0] e_stat;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1: apply inputs, sample comb at negedge, regs after edge.
  task automatic step(input logic [2:0] v, input logic ordy,
                      input logic en, input logic clr,
                      input logic [1:0] sel);
    src_valid   = v;
    order_ready = ordy;
    arb_enable  = en;
    stat_clear  = clr;
    stat_sel    = sel;
    @(negedge clk);
    rdy_s  = src_ready;
    stat_s = stat_count;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_valid = '0;
    stat_clear = 1'b0;
    d1 = DB;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vt[0]  = '{3'b111, 1, 1, 2'd0, DB, 3'b001, 1, 2'd0, DA, 0};
    vt[1]  = '{3'b111, 1, 1, 2'd0, DB, 3'b010, 1, 2'd1, DB, 1};
    vt[2]  = '{3'b111, 1, 1, 2'd1, DB, 3'b100, 1, 2'd2, DC, 1};
    vt[3]  = '{3'b111, 1, 1, 2'd2, DB, 3'b001, 1, 2'd0, DA, 1};
    vt[4]  = '{3'b111, 1, 1, 2'd0, DB, 3'b010, 1, 2'd1, DB, 2};
    vt[5]  = '{3'b111, 1, 1, 2'd1, DB, 3'b100, 1, 2'd2, DC, 2};
    vt[6]  = '{3'b111, 1, 1, 2'd2, DB, 3'b001, 1, 2'd0, DA, 2};
    vt[7]  = '{3'b111, 1, 1, 2'd0, DX, 3'b010, 1, 2'd1, DX, 3};
    vt[8]  = '{3'b111, 0, 1, 2'd1, DX, 3'b000, 1, 2'd1, DX, 3};
    vt[9]  = '{3'b111, 0, 1, 2'd3, DX, 3'b000, 1, 2'd1, DX, 0};
    vt[10] = '{3'b111, 0, 1, 2'd1, DX, 3'b000, 1, 2'd1, DX, 3};
    vt[11] = '{3'b111, 0, 1, 2'd2, DX, 3'b000, 1, 2'd1, DX, 2};
    vt[12] = '{3'b111, 1, 1, 2'd2, DX, 3'b100, 1, 2'd2, DC, 2};
    vt[13] = '{3'b111, 1, 0, 2'd2, DB, 3'b000, 0, 2'd2, DC, 3};
    vt[14] = '{3'b111, 1, 0, 2'd0, DB, 3'b000, 0, 2'd2, DC, 3};
    vt[15] = '{3'b110, 1, 1, 2'd1, DB, 3'b010, 1, 2'd1, DB, 3};
    vt[16] = '{3'b000, 1, 1, 2'd1, DB, 3'b000, 0, 2'd1, DB, 4};

    // Round-robin, backpressure, enable gating and drain.
    do_reset();
    chk("reset_ov", {31'd0, order_valid}, 0);
    chk("reset_od", order_data, 0);
    chk("reset_os", {30'd0, order_src}, 0);
    for (int i = 0; i < 17; i++) begin
      d1 = vt[i].d1;
      step(vt[i].v, vt[i].ordy, vt[i].en, 1'b0, vt[i].sel);
      chk($sformatf("v%0d_rdy", i), {29'd0, rdy_s}, {29'd0, vt[i].e_rdy});
      chk($sformatf("v%0d_stat", i), stat_s, vt[i].e_stat);
      chk($sformatf("v%0d_ov", i), {31'd0, order_valid}, {31'd0, vt[i].e_ov});
      chk($sformatf("v%0d_os", i), {30'd0, order_src}, {30'd0, vt[i].e_os});
      chk($sformatf("v%0d_od", i), order_data, vt[i].e_od);
    end

    // Rate limit: only source 2, grants at 0..7 then one per refill.
    do_reset();
    for (int c = 0; c < 50; c++) begin
      logic exp_g;
      exp_g = (c < 8) || (c == 16) || (c == 32) || (c == 48);
      step(3'b100, 1'b1, 1'b1, 1'b0, 2'd2);
      chk($sformatf("rate_c%0d_rdy2", c), {31'd0, rdy_s[2]}, {31'd0, exp_g});
    end
    step(3'b000, 1'b1, 1'b1, 1'b0, 2'd2);
    chk("rate_stat2", stat_s, 32'd11);

    // Starvation bypass: drain source 0, then source 1 runs alone.
    do_reset();
    for (int c = 0; c < 8; c++) step(3'b001, 1'b1, 1'b1, 1'b0, 2'd0);
    for (int c = 8; c < 16; c++) begin
      step(3'b011, 1'b1, 1'b1, 1'b0, 2'd0);
      chk($sformatf("starve_c%0d_rdy", c), {29'd0, rdy_s}, 32'b010);
      chk($sformatf("starve_c%0d_os", c), {30'd0, order_src}, 32'd1);
    end
    step(3'b011, 1'b1, 1'b1, 1'b0, 2'd0);
    chk("starve_c16_rdy", {29'd0, rdy_s}, 32'b001);
    chk("starve_c16_os", {30'd0, order_src}, 32'd0);
    step(3'b011, 1'b1, 1'b1, 1'b0, 2'd0);
    chk("starve_c17_rdy", {29'd0, rdy_s}, 32'b010);
    step(3'b011, 1'b1, 1'b1, 1'b0, 2'd0);
    chk("starve_c18_rdy", {29'd0, rdy_s}, 32'b000);
    chk("starve_c18_ov", {31'd0, order_valid}, 32'd0);

    // Clear collides with a grant to source 0.
    do_reset();
    for (int c = 0; c < 5; c++) step(3'b001, 1'b1, 1'b1, 1'b0, 2'd0);
    step(3'b001, 1'b1, 1'b1, 1'b1, 2'd0);
    chk("clr_pre", stat_s, 32'd5);
    chk("clr_rdy", {29'd0, rdy_s}, 32'b001);
    step(3'b001, 1'b1, 1'b1, 1'b0, 2'd0);
    chk("clr_zero", stat_s, 32'd0);
    step(3'b000, 1'b1, 1'b1, 1'b0, 2'd0);
    chk("clr_one", stat_s, 32'd1);

    // Asynchronous reset while an order is registered.
    do_reset();
    step(3'b111, 1'b1, 1'b1, 1'b0, 2'd0);
    step(3'b111, 1'b1, 1'b1, 1'b0, 2'd0);
    chk("rst_mid_ov_pre", {31'd0, order_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ov", {31'd0, order_valid}, 32'd0);
    chk("rst_mid_rdy", {29'd0, src_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(3'b111, 1'b1, 1'b1, 1'b0, 2'd0);
    chk("rst_first_rdy", {29'd0, rdy_s}, 32'b001);
    chk("rst_first_stat", stat_s, 32'd0);
    chk("rst_first_os", {30'd0, order_src}, 32'd0);
    chk("rst_first_od", order_data, DA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/order_ingress_arbiter.md
Name: order_ingress_arbiter

Overview:
- Shares the matching engine's single order input (order_data/order_valid) between NUM_SRC order sources: direct order port, TCP RX decode, AXI-stream ingress.
- Round-robin arbitration, gated by a per-source token-bucket rate limiter.
- One registered output stage in front of the engine.
- Per-source accepted-order counters for monitoring.

Parameters:
- NUM_SRC, 3, number of requesters (2..8).
- DATA_W, 32, order word width.
- TOKEN_MAX, 8, bucket depth per source; also the reset token count (1..255).
- REFILL_PERIOD, 16, cycles between token refills (2..65535).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- arb_enable  in  1  1 = new grants allowed.
- src_data  in  NUM_SRC*DATA_W  source i occupies bits [i*DATA_W +: DATA_W].
- src_valid  in  NUM_SRC  per-source request.
- src_ready  out  NUM_SRC  per-source accept (combinational, one-hot or zero).
- order_data  out  DATA_W  registered order to engine.
- order_valid  out  1  order_data valid.
- order_ready  in  1  engine accepts (tie 1 if engine has no backpressure).
- order_src  out  $clog2(NUM_SRC)  index of the source that supplied order_data.
- stat_sel  in  $clog2(NUM_SRC)  counter select.
- stat_clear  in  1  synchronous clear of all counters.
- stat_count  out  32  accepted-order count of the stat_sel source (combinational mux).

Behaviour:
- Reset values (async, while rst_n=0):
  - order_valid=0, order_data=0, order_src=0.
  - Every token counter = TOKEN_MAX; refill timer = 0; last_grant = NUM_SRC-1 (so source 0 wins first); all stat counters = 0.
  - src_ready is then all 0 because order_valid=0 does not block, but arbitration is gated by reset.
- pipe_ready = !order_valid || order_ready.
- Eligibility: eligible[i] = src_valid[i] && tokens[i]!=0.
- Grant: when arb_enable && pipe_ready, grant the first eligible index scanning last_grant+1, last_grant+2, …, wrapping modulo NUM_SRC. src_ready[grant]=1; all other src_ready bits = 0. With no eligible source, all src_ready = 0.
- Transfer: src_valid[g] && src_ready[g]. On the next edge:
  - order_data <= src_data[g]; order_src <= g; order_valid <= 1.
  - last_grant <= g; tokens[g] decrements; stat[g] increments (32-bit wrap).
- Latency: source handshake to order_valid is exactly 1 cycle. Back-to-back orders sustain 1 order/cycle while order_ready=1.
- Hold: order_valid && !order_ready keeps order_data and order_src stable, and no grant is issued.
- Drain: when order_valid && order_ready && no transfer, order_valid <= 0 on the next edge.
- arb_enable=0: no grants. An already-registered order still drains normally. last_grant is unchanged.
- Refill timer:
  - Counts 0..REFILL_PERIOD-1, then wraps to 0.
  - On the wrap cycle, every tokens[i] < TOKEN_MAX increments by 1. Tokens saturate at TOKEN_MAX.
  - Refill and consume on the same source in the same cycle: net change 0. If tokens[i] == TOKEN_MAX, the result is TOKEN_MAX-1.
- Token exhaustion: a source at 0 tokens is skipped. Other sources are served even if the starved source is next in round-robin order.
- Counters: stat_clear has priority. If stat_clear and a transfer occur in the same cycle, the counter ends at 0.
- Out-of-range stat_sel (>= NUM_SRC): stat_count = 0.
- Async reset mid-transfer drops the registered order with no partial state. Sources must re-present their data.
- A source's src_valid falling without a handshake is legal and costs no token.

Test Plan:
- Round-robin fairness: NUM_SRC=3, all src_valid=1 constantly, order_ready=1, distinct data 0xA0000001/0xB0000002/0xC0000003. Required: order_src sequence 0,1,2,0,1,2; order_valid high from cycle 1 onward; each source loses 1 token per grant.
- Backpressure: order_ready=0 for 4 cycles while order_valid=1 with src 1 data 0x80000005. Required: order_data and order_src stable; src_ready=0; no counter or token change; transfer resumes on the cycle order_ready returns to 1.
- Rate limit: TOKEN_MAX=8, REFILL_PERIOD=16; only source 2 valid from reset.
  - Required: 8 grants in cycles 0..7, then src_ready[2]=0 until the refill wrap at cycle 15.
  - Then 1 grant per 16 cycles; stat_count(sel=2) = 8 + refills.
- Starvation bypass: source 0 at 0 tokens and source 1 valid with tokens. Required: source 1 granted every cycle; source 0 is granted on the first cycle after refill, in round-robin order.
- Counter clear: stat_clear asserted in the same cycle as a grant to source 0 with count 5. Required: count reads 0 next cycle and 1 after the next grant.
- Reset mid-stream: assert rst_n=0 asynchronously while order_valid=1. Required: order_valid=0 immediately; after release, tokens=TOKEN_MAX and the first grant goes to source 0.
